add_accumulator: RTL and testbench

ADD_ACCUMULATOR -- requirements
Module: add_accumulator

---
 rtl/add_accumulator.sv | 126 ++++++++++++
 tb/tb_add_accumulator.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/add_accumulator.sv
// add_accumulator
//   Adds a packet of operands, with a carry-in for each one, into a single
//   accumulator. When the operand flagged in_last is accepted, the result is
//   held on the out_* ports until the consumer takes it.
//
//   Ports
//     clk        single clock; every state change happens on its rising edge
//     rst_n      asynchronous active-low reset
//     clr        synchronous clear; drops the packet in progress
//     in_valid   an operand is offered
//     in_ready   the operand is accepted when in_valid & in_ready
//     in_data    operand (WIDTH bits) added to the accumulator
//     in_cin     carry-in for this operand's addition
//     in_last    marks the final operand of the packet
//     out_valid  a packet result is being held
//     out_ready  the result is consumed when out_valid & out_ready
//     out_sum    final accumulator value
//     out_cout   carry-out of the final addition only
//     out_of     signed overflow, sticky across the whole packet
//     out_count  number of operands accepted in the packet (saturates)
//     busy       high while a packet is open or a result is held
module add_accumulator #(
   parameter int WIDTH = 32,
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             clr,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   input  logic             in_cin,
   input  logic             in_last,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_sum,
   output logic             out_cout,
   output logic             out_of,
   output logic [CNT_W-1:0] out_count,
   output logic             busy
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ACCUM = 2'd1,
      HOLD  = 2'd2
   } state_t;

   state_t           state;
   logic [WIDTH-1:0] acc;
   logic             cout;
   logic             of;
   logic [CNT_W-1:0] count;

   logic             accept;
   logic [WIDTH:0]   sum_ext;

   // Two's-complement overflow: both addends share a sign and the result
   // does not.
   function automatic logic add_ovf(input logic a_msb, input logic b_msb,
                                    input logic s_msb);
      return ~(a_msb ^ b_msb) & (a_msb ^ s_msb);
   endfunction

   // Operand counter stops at its all-ones value instead of wrapping.
   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
      return (&c) ? c : c + {{(CNT_W-1){1'b0}}, 1'b1};
   endfunction

   // in_ready is the only output with a path from an input: a clear in
   // the same cycle has to block the operand on offer.
   assign in_ready  = (state != HOLD) & ~clr;
   assign accept    = in_valid & in_ready;
   assign out_valid = (state == HOLD);
   assign busy      = (state != IDLE);

   // One extra bit catches the unsigned carry out of bit WIDTH-1.
   assign sum_ext = {1'b0, acc} + {1'b0, in_data} + {{WIDTH{1'b0}}, in_cin};

   assign out_sum   = acc;
   assign out_cout  = cout;
   assign out_of    = of;
   assign out_count = count;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         acc   <= '0;
         cout  <= 1'b0;
         of    <= 1'b0;
         count <= '0;
      end else if (clr) begin
         state <= IDLE;
         acc   <= '0;
         cout  <= 1'b0;
         of    <= 1'b0;
         count <= '0;
      end else begin
         case (state)
            IDLE, ACCUM: begin
               if (accept) begin
                  acc   <= sum_ext[WIDTH-1:0];
                  cout  <= sum_ext[WIDTH];
                  of    <= of | add_ovf(acc[WIDTH-1], in_data[WIDTH-1],
                                        sum_ext[WIDTH-1]);
                  count <= sat_inc(count);
                  state <= in_last ? HOLD : ACCUM;
               end
            end
            HOLD: begin
               // The result stays frozen until the consumer takes it; the
               // handshake also empties the accumulator for the next packet.
               if (out_ready) begin
                  state <= IDLE;
                  acc   <= '0;
                  cout  <= 1'b0;
                  of    <= 1'b0;
                  count <= '0;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_add_accumulator.sv
module tb_add_accumulator;

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic        clr = 1'b0;
   logic        in_valid = 1'b0;
   logic [31:0] in_data = '0;
   logic        in_cin = 1'b0;
   logic        in_last = 1'b0;
   logic        out_ready = 1'b1;

   logic        in_ready_a, out_valid_a, out_cout_a, out_of_a, busy_a;
   logic [31:0] out_sum_a;
   logic [7:0]  out_count_a;
   logic        in_ready_b, out_valid_b, out_cout_b, out_of_b, busy_b;
   logic [31:0] out_sum_b;
   logic [1:0]  out_count_b;

   int n_tests = 0;
   int n_fail  = 0;
   bit cmp_en  = 1'b0;

   always #5 clk = ~clk;

   add_accumulator #(.WIDTH(32), .CNT_W(8)) u_dut (
      .clk(clk), .rst_n(rst_n), .clr(clr),
      .in_valid(in_valid), .in_ready(in_ready_a), .in_data(in_data),
      .in_cin(in_cin), .in_last(in_last),
      .out_valid(out_valid_a), .out_ready(out_ready), .out_sum(out_sum_a),
      .out_cout(out_cout_a), .out_of(out_of_a), .out_count(out_count_a),
      .busy(busy_a)
   );

   // Same stimulus into a narrow-counter copy to exercise saturation.
   add_accumulator #(.WIDTH(32), .CNT_W(2)) u_dut_c2 (
      .clk(clk), .rst_n(rst_n), .clr(clr),
      .in_valid(in_valid), .in_ready(in_ready_b), .in_data(in_data),
      .in_cin(in_cin), .in_last(in_last),
      .out_valid(out_valid_b), .out_ready(out_ready), .out_sum(out_sum_b),
      .out_cout(out_cout_b), .out_of(out_of_b), .out_count(out_count_b),
      .busy(busy_b)
   );

   // Behavioural model: packet arithmetic on wide integers.
   longint unsigned m_acc  = 0;
   bit              m_cout = 0;
   bit              m_of   = 0;
   int unsigned     m_n    = 0;
   bit              m_open = 0;
   bit              m_hold = 0;

   task automatic m_clear();
      m_acc = 0; m_cout = 0; m_of = 0; m_n = 0; m_open = 0; m_hold = 0;
   endtask

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_clear();
      end else if (clr) begin
         m_clear();
      end else if (m_hold) begin
         if (out_ready) m_clear();
      end else if (in_valid) begin
         longint unsigned s;
         longint          ss;
         s  = m_acc + longint'(in_data) + longint'(in_cin);
         ss = longint'($signed(m_acc[31:0])) + longint'($signed(in_data))
              + longint'(in_cin);
         m_cout = (s >= 64'h1_0000_0000);
         m_of   = m_of | (ss > 64'sd2147483647) | (ss < -64'sd2147483648);
         m_acc  = s & 64'hFFFF_FFFF;
         m_n    = m_n + 1;
         m_hold = in_last;
         m_open = !in_last;
      end
   end

   task automatic chk(input string nm, input logic [63:0] act,
                      input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
      end
   endtask

   // Every cycle: all outputs of both instances against the model.
   always @(negedge clk) begin
      if (cmp_en) begin
         chk("cmp_valid",  {63'd0, out_valid_a}, {63'd0, m_hold});
         chk("cmp_ready",  {63'd0, in_ready_a},  {63'd0, !m_hold && !clr});
         chk("cmp_busy",   {63'd0, busy_a},      {63'd0, m_hold | m_open});
         chk("cmp_sum",    {32'd0, out_sum_a},   m_acc);
         chk("cmp_cout",   {63'd0, out_cout_a},  {63'd0, m_cout});
         chk("cmp_of",     {63'd0, out_of_a},    {63'd0, m_of});
         chk("cmp_count8", {56'd0, out_count_a}, (m_n > 255) ? 64'd255 : 64'(m_n));
         chk("cmp_valid2", {63'd0, out_valid_b}, {63'd0, m_hold});
         chk("cmp_sum2",   {32'd0, out_sum_b},   m_acc);
         chk("cmp_count2", {62'd0, out_count_b}, (m_n > 3) ? 64'd3 : 64'(m_n));
      end
   end

   task automatic drive(input logic [31:0] d, input logic c, input logic l);
      in_valid = 1'b1; in_data = d; in_cin = c; in_last = l;
      @(posedge clk); #1;
      in_valid = 1'b0; in_data = '0; in_cin = 1'b0; in_last = 1'b0;
   endtask

   task automatic step();
      @(posedge clk); #1;
   endtask

   initial begin
      #2 rst_n = 1'b0;
      #1;
      cmp_en = 1'b1;
      chk("rst_valid", {63'd0, out_valid_a}, 64'd0);
      chk("rst_busy",  {63'd0, busy_a},      64'd0);
      chk("rst_ready", {63'd0, in_ready_a},  64'd1);
      chk("rst_sum",   {32'd0, out_sum_a},   64'd0);
      #19 rst_n = 1'b1;
      step();

      // 5 + 7 + 9
      drive(32'd5, 1'b0, 1'b0);
      drive(32'd7, 1'b0, 1'b0);
      drive(32'd9, 1'b0, 1'b1);
      chk("p1_valid", {63'd0, out_valid_a}, 64'd1);
      chk("p1_sum",   {32'd0, out_sum_a},   64'd21);
      chk("p1_count", {56'd0, out_count_a}, 64'd3);
      chk("p1_cout",  {63'd0, out_cout_a},  64'd0);
      chk("p1_of",    {63'd0, out_of_a},    64'd0);
      step();
      chk("p1_done",  {63'd0, out_valid_a}, 64'd0);

      // signed overflow
      drive(32'h7FFF_FFFF, 1'b0, 1'b0);
      drive(32'h0000_0001, 1'b0, 1'b1);
      chk("p2_sum",  {32'd0, out_sum_a},  64'h8000_0000);
      chk("p2_of",   {63'd0, out_of_a},   64'd1);
      chk("p2_cout", {63'd0, out_cout_a}, 64'd0);
      step();

      // unsigned carry with carry-in
      drive(32'hFFFF_FFFF, 1'b0, 1'b0);
      drive(32'h0000_0002, 1'b1, 1'b1);
      chk("p3_sum",  {32'd0, out_sum_a},  64'd2);
      chk("p3_cout", {63'd0, out_cout_a}, 64'd1);
      chk("p3_of",   {63'd0, out_of_a},   64'd0);
      step();

      // back-pressure on the result
      out_ready = 1'b0;
      drive(32'h10, 1'b0, 1'b1);
      in_valid = 1'b1; in_data = 32'h55; in_last = 1'b1;
      for (int i = 0; i < 4; i++) begin
         chk("p4_hold_valid", {63'd0, out_valid_a}, 64'd1);
         chk("p4_hold_ready", {63'd0, in_ready_a},  64'd0);
         chk("p4_hold_sum",   {32'd0, out_sum_a},   64'h10);
         chk("p4_hold_count", {56'd0, out_count_a}, 64'd1);
         step();
      end
      out_ready = 1'b1; in_valid = 1'b0; in_data = '0; in_last = 1'b0;
      step();
      chk("p4_rel_valid", {63'd0, out_valid_a}, 64'd0);
      chk("p4_rel_busy",  {63'd0, busy_a},      64'd0);
      chk("p4_rel_sum",   {32'd0, out_sum_a},   64'd0);
      drive(32'd4, 1'b0, 1'b1);
      chk("p4_next_sum",  {32'd0, out_sum_a},   64'd4);
      step();

      // clear mid-packet beats an offered operand
      drive(32'd1, 1'b0, 1'b0);
      drive(32'd2, 1'b0, 1'b0);
      clr = 1'b1; in_valid = 1'b1; in_data = 32'd100;
      #1;
      chk("p5_clr_ready", {63'd0, in_ready_a}, 64'd0);
      @(posedge clk); #1;
      clr = 1'b0; in_valid = 1'b0; in_data = '0;
      chk("p5_clr_busy",  {63'd0, busy_a},      64'd0);
      chk("p5_clr_count", {56'd0, out_count_a}, 64'd0);
      drive(32'd3, 1'b0, 1'b1);
      chk("p5_sum",   {32'd0, out_sum_a},   64'd3);
      chk("p5_count", {56'd0, out_count_a}, 64'd1);
      step();

      // five operands: narrow counter saturates
      for (int i = 0; i < 5; i++) drive(32'd1, 1'b0, (i == 4));
      chk("p6_sum",    {32'd0, out_sum_a},   64'd5);
      chk("p6_count8", {56'd0, out_count_a}, 64'd5);
      chk("p6_count2", {62'd0, out_count_b}, 64'd3);
      chk("p6_sum2",   {32'd0, out_sum_b},   64'd5);
      step();

      // asynchronous reset mid-packet
      drive(32'd1, 1'b0, 1'b0);
      drive(32'd1, 1'b0, 1'b0);
      in_valid = 1'b1; in_data = 32'd1; in_last = 1'b1;
      #2 rst_n = 1'b0;
      #1;
      chk("p7_rst_valid", {63'd0, out_valid_a}, 64'd0);
      chk("p7_rst_busy",  {63'd0, busy_a},      64'd0);
      chk("p7_rst_sum",   {32'd0, out_sum_a},   64'd0);
      @(posedge clk); #2;
      rst_n = 1'b1; in_valid = 1'b0; in_data = '0; in_last = 1'b0;
      for (int i = 0; i < 3; i++) begin
         step();
         chk("p7_no_result", {63'd0, out_valid_a}, 64'd0);
      end

      step();
      cmp_en = 1'b0;
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #50000;
      $display("FAIL timeout: bench did not finish, got running expected done");
      $fatal(1, "timeout");
   end

endmodule
